risc_load_store_unit_32: RTL and testbench
==========================================

# risc_load_store_unit_32

Load/store unit for the 32-bit RISC-V microprocessor. It sits directly upstream of the 64-entry word-wide data memory and converts core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Sub-word loads are byte-lane selected and extended. Sub-word stores are done as a read-modify-write, because the memory only supports full-word synchronous writes with asynchronous reads.

## Interface
- MEM_WORDS, 64: data memory depth in words; byte addresses at or above MEM_WORDS*4 fault.
- clk  in  1  single clock; all state updates on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit idle and accepting requests.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte or halfword used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  misaligned or out-of-range access; valid with resp_valid.
- mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00} to the data memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory asynchronous read data.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, funct3, addr and wdata.
  - Fault detected: go to RESP with fault=1. No memory access.
  - Load: go to RD.
  - SW: go to WR.
  - SB/SH: go to RD.
- RD:
  - mem_we=0; mem_rdata is sampled at the edge.
  - Load: extract lane addr[1:0] (byte) or addr[1] (half). Sign-extend for B/H, zero-extend for BU/HU, pass through for W. Result goes to resp_rdata; next state RESP.
  - Sub-word store: merge the store byte or half into the read word at its lane. Store in the write buffer; next state WR.
- WR: mem_we=1, mem_wdata = write buffer (SW: latched wdata). The memory commits at the edge; next state RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request is not accepted in RESP.
- mem_addr, mem_we and mem_wdata are decoded from state and the latched registers. mem_we is 1 only in WR.
- Fault conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr >= MEM_WORDS*4.
  - funct3 011, 110 or 111.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Count latency from the accepting edge (req_valid & req_ready) to the resp_valid cycle:
  - Loads: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Faults: 1 cycle.
- The RMW read and write are in consecutive cycles. This unit is the memory's only master, so there is no intervening write.
- req_valid held in non-IDLE states is ignored. The core must hold the request until req_ready is 1.
- When areset asserts mid-operation, the FSM drops to IDLE immediately and mem_we falls asynchronously. A pending WR is never issued. A partially completed RMW leaves memory unchanged.
- No back-pressure on the response: resp_valid is a pulse and must be consumed in that cycle.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned H/W accesses fault as described above.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misalignment is not checked. The address low bits are forced to natural alignment (addr[0]=0 for H, addr[1:0]=0 for W) and the access proceeds.
  - Out-of-range and illegal-funct3 faults still apply.

## Test plan
- After reset, SW of 0xDEADBEEF to addr 0x10, then LW 0x10 -> resp_rdata=0xDEADBEEF, 2-cycle latency, fault=0.
- SB 0x5A to 0x11 over word 0xDEADBEEF, then LW 0x10 -> 0xDEAD5AEF. Store response arrives 3 cycles after accept, and mem_we is high for exactly one cycle.
- LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x12 -> 0xFFFFDEAD. LHU 0x12 -> 0x0000DEAD.
- LW 0x12 with the macro defined -> fault=1, rdata=0, 1-cycle latency, no memory access. Without the macro -> returns the word at 0x10.
- SW to 0x100 (MEM_WORDS=64) -> fault=1, mem_we never asserts.
- SH accepted, with areset pulsed while in RD -> no write occurs, req_ready=1 after reset, and memory is unchanged on readback.

Source files
------------

// File: rtl/risc_load_store_unit_32_if.sv
// Bus bundle for risc_load_store_unit_32.
// Groups the core request/response handshake and the data-memory port.
//   slave  : the load/store unit side
//              inputs  req_*, mem_rdata
//              outputs req_ready, resp_*, mem_addr/mem_we/mem_wdata
//   master : the core plus data-memory side, with the opposite directions
interface risc_load_store_unit_32_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/risc_load_store_unit_32.sv
// Load/store unit for a 32-bit RISC-V core in front of a word-wide data memory.
// It turns LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses. Sub-word stores are
// done as a read-modify-write because the memory can only write whole words.
// Ports:
//   clk     : clock, rising edge
//   areset  : asynchronous active-high reset
//   bus     : risc_load_store_unit_32_if.slave (request, response, memory port)
// Parameter:
//   MEM_WORDS : memory depth in words; byte addresses >= MEM_WORDS*4 fault
// Build option:
//   LSU_MISALIGN_TRAP_EN defined   -> misaligned H/W accesses fault
//   LSU_MISALIGN_TRAP_EN undefined -> the low address bits are forced to natural
//                                     alignment and the access proceeds
module risc_load_store_unit_32 #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic clk,
    input  logic areset,
    risc_load_store_unit_32_if.slave bus
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_n;
    logic        lat_write, lat_write_n;
    logic [1:0]  lat_size, lat_size_n;
    logic        lat_uns, lat_uns_n;
    logic [31:0] lat_addr, lat_addr_n;
    logic [31:0] wbuf, wbuf_n;
    logic        resp_valid_q, resp_valid_n;
    logic [31:0] resp_rdata_q, resp_rdata_n;
    logic        resp_fault_q, resp_fault_n;

    logic [1:0]  req_size;
    logic        req_fault;
    logic [31:0] req_addr_al;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;
    logic [31:0] merged;

    // Request decode: access size, fault detection, address alignment
    always_comb begin
        req_size    = bus.req_funct3[1:0];
        req_addr_al = bus.req_addr;
        req_fault   = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                      (bus.req_addr >= ADDR_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == 2'b01 && bus.req_addr[0]) ||
            (req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)) begin
            req_fault = 1'b1;
        end
`else
        if (req_size == 2'b01) begin
            req_addr_al[0] = 1'b0;
        end else if (req_size == 2'b10) begin
            req_addr_al[1:0] = 2'b00;
        end
`endif
    end

    // Lane select/extension for loads and lane merge for sub-word stores
    always_comb begin
        rd_byte = bus.mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
        rd_half = bus.mem_rdata[{lat_addr[1], 4'b0000} +: 16];
        case (lat_size)
            2'b00:   rd_ext = lat_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = lat_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = bus.mem_rdata;
        endcase
        merged = bus.mem_rdata;
        if (lat_size == 2'b00) begin
            merged[{lat_addr[1:0], 3'b000} +: 8] = wbuf[7:0];
        end else begin
            merged[{lat_addr[1], 4'b0000} +: 16] = wbuf[15:0];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state        <= IDLE;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_uns      <= 1'b0;
            lat_addr     <= 32'h0;
            wbuf         <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            state        <= state_n;
            lat_write    <= lat_write_n;
            lat_size     <= lat_size_n;
            lat_uns      <= lat_uns_n;
            lat_addr     <= lat_addr_n;
            wbuf         <= wbuf_n;
            resp_valid_q <= resp_valid_n;
            resp_rdata_q <= resp_rdata_n;
            resp_fault_q <= resp_fault_n;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_n      = state;
        lat_write_n  = lat_write;
        lat_size_n   = lat_size;
        lat_uns_n    = lat_uns;
        lat_addr_n   = lat_addr;
        wbuf_n       = wbuf;
        resp_valid_n = 1'b0;
        resp_rdata_n = 32'h0;
        resp_fault_n = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    lat_write_n = bus.req_write;
                    lat_size_n  = req_size;
                    lat_uns_n   = bus.req_funct3[2];
                    lat_addr_n  = req_addr_al;
                    wbuf_n      = bus.req_wdata;
                    if (req_fault) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_fault_n = 1'b1;
                    end else if (bus.req_write && req_size == 2'b10) begin
                        state_n = WR;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD: begin
                if (lat_write) begin
                    wbuf_n  = merged;
                    state_n = WR;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = rd_ext;
                end
            end
            WR: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Memory port and handshake decoded from state and latched registers
    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_we     = (state == WR);
    assign bus.mem_addr   = {lat_addr[31:2], 2'b00};
    assign bus.mem_wdata  = wbuf;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;

endmodule

// File: tb/tb_risc_load_store_unit_32.sv
// Self-checking bench for risc_load_store_unit_32 with a 64-word data memory.
module tb_risc_load_store_unit_32;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          we_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic areset = 1'b1;
    risc_load_store_unit_32_if bus();

    risc_load_store_unit_32 #(.MEM_WORDS(64)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    int checks = 0;
    int errors = 0;
    exp_t expq[$];
    exp_t mon_e;
    logic [31:0] last_rdata;
    logic last_fault;
    bit pending = 0;
    int since = 0;
    int we_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: what an access must return, and its effect on memory
    function automatic exp_t model(input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int sz;
        int off;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] val;
        bit bad;
        sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mask = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        bad  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (a >= 32'd256);
`ifdef LSU_MISALIGN_TRAP_EN
        if (a % sz != 0) bad = 1;
`else
        a = a - a % sz;
`endif
        e.rdata = 32'h0;
        e.fault = bad;
        e.we_cycles = 0;
        if (bad) begin
            e.lat = 1;
            return e;
        end
        off  = int'(a % 4);
        word = ref_mem[a / 4];
        if (wr) begin
            word = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            ref_mem[a / 4] = word;
            e.lat = (sz == 4) ? 2 : 3;
            e.we_cycles = 1;
        end else begin
            val = (word >> (8 * off)) & mask;
            if (!f3[2] && sz < 4 && val[8 * sz - 1]) val = val | ~mask;
            e.rdata = val;
            e.lat = 2;
        end
        return e;
    endfunction

    // Compare process: latency, data, fault and write count per response
    always @(negedge clk) begin
        if (areset) begin
            pending = 0;
            since = 0;
            we_cnt = 0;
            chk("mem_we_in_reset", 32'(bus.mem_we), 32'h0);
        end else begin
            if (pending) since++;
            if (bus.mem_we) we_cnt++;
            if (bus.resp_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_resp", 32'(bus.resp_valid), 32'h0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
                    chk("resp_fault", 32'(bus.resp_fault), 32'(mon_e.fault));
                    chk("latency", 32'(since), 32'(mon_e.lat));
                    chk("mem_we_cycles", 32'(we_cnt), 32'(mon_e.we_cycles));
                    chk("ready_in_resp", 32'(bus.req_ready), 32'h0);
                end
                last_rdata = bus.resp_rdata;
                last_fault = bus.resp_fault;
                pending = 0;
                we_cnt = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
                pending = 1;
                since = 0;
                we_cnt = 0;
            end
        end
    end

    task automatic do_req(input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.req_ready && n < 20);
        if (!bus.req_ready) chk("ready_timeout", 32'(bus.req_ready), 32'h1);
        expq.push_back(model(wr, f3, a, wd));
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (expq.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            chk("resp_timeout", 32'(expq.size()), 32'h0);
            expq.delete();
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] rd, input logic f);
        chk({nm, "_rdata"}, last_rdata, rd);
        chk({nm, "_fault"}, 32'(last_fault), 32'(f));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_fault", 32'(bus.resp_fault), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        areset = 1'b0;

        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF);
        lit("sw", 32'h0, 1'b0);
        do_req(0, 3'b010, 32'h10, 32'h0);
        lit("lw_10", 32'hDEADBEEF, 1'b0);
        do_req(1, 3'b000, 32'h11, 32'h0000005A);
        do_req(0, 3'b010, 32'h10, 32'h0);
        lit("lw_after_sb", 32'hDEAD5AEF, 1'b0);
        do_req(0, 3'b000, 32'h13, 32'h0);
        lit("lb_13", 32'hFFFFFFDE, 1'b0);
        do_req(0, 3'b100, 32'h13, 32'h0);
        lit("lbu_13", 32'h000000DE, 1'b0);
        do_req(0, 3'b001, 32'h12, 32'h0);
        lit("lh_12", 32'hFFFFDEAD, 1'b0);
        do_req(0, 3'b101, 32'h12, 32'h0);
        lit("lhu_12", 32'h0000DEAD, 1'b0);

        do_req(0, 3'b010, 32'h12, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        lit("lw_12_misaligned", 32'h0, 1'b1);
`else
        lit("lw_12_forced", 32'hDEAD5AEF, 1'b0);
`endif
        do_req(1, 3'b010, 32'h100, 32'h12345678);
        lit("sw_out_of_range", 32'h0, 1'b1);

        do_req(1, 3'b001, 32'h16, 32'h1234ABCD);
        do_req(0, 3'b001, 32'h16, 32'h0);
        lit("lh_16", 32'hFFFFABCD, 1'b0);
        do_req(1, 3'b000, 32'h14, 32'h00000080);
        do_req(0, 3'b000, 32'h14, 32'h0);
        lit("lb_14", 32'hFFFFFF80, 1'b0);
        do_req(0, 3'b010, 32'h14, 32'h0);
        lit("lw_14", 32'hABCD0080, 1'b0);
        do_req(0, 3'b011, 32'h0, 32'h0);
        lit("illegal_f3", 32'h0, 1'b1);
        do_req(1, 3'b010, 32'hFC, 32'hCAFEF00D);
        do_req(0, 3'b100, 32'hFF, 32'h0);
        lit("lbu_last_byte", 32'h000000CA, 1'b0);
        do_req(0, 3'b000, 32'h100, 32'h0);
        lit("lb_out_of_range", 32'h0, 1'b1);

        // SH accepted, then reset while the RMW read is in flight
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h12;
        bus.req_wdata  = 32'h00007777;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #1 areset = 1'b1;
        #1 chk("abort_mem_we", 32'(bus.mem_we), 32'h0);
        @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        #1 chk("abort_ready", 32'(bus.req_ready), 32'h1);
        chk("abort_mem_word", mem[4], 32'hDEAD5AEF);
        do_req(0, 3'b010, 32'h10, 32'h0);
        lit("lw_after_abort", 32'hDEAD5AEF, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
